vec_mem_seq: RTL and testbench
==============================

Name: vec_mem_seq

Overview:
- Multi-cycle vector memory sequencer in the memory stage of the vector CPU.
- Consumes the registered control word from the execute/memory pipeline register (cl_mem_op, cl_vec_wr), the base address and the store vector.
- Splits one vector load or store into LANES single-element memory accesses with a programmable stride.
- Drives stall to freeze upstream pipeline registers while busy, then presents the assembled load vector and write-back control for one cycle.

Parameters:
LANES, 4, number of vector elements per access (>=2)
DW, 16, element width in bits
AW, 16, memory address width in bits

Ports:
clk  in  1  single clock; all state updates on the falling edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  control word at the inputs is a live instruction
mem_op  in  2  00 none, 01 vector load, 10 vector store, 11 reserved (treated as none)
vec_wr_in  in  2  vector write-back control travelling with the instruction
base_addr  in  AW  element 0 address
stride  in  AW  address increment between consecutive elements
wdata_vec  in  LANES*DW  store data; lane i = bits [i*DW +: DW]
mem_addr  out  AW  memory address
mem_re  out  1  read strobe
mem_we  out  1  write strobe
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid one cycle after mem_re
rdata_vec  out  LANES*DW  assembled load vector
vec_wr_out  out  2  write-back control for the completed load
done  out  1  one-cycle completion pulse
stall  out  1  1 = upstream pipeline enables must be low

Behaviour:
- States: IDLE, LOAD, LOAD_WAIT, STORE, DONE.
- Reset (sync, falling edge): state=IDLE, idx=0, addr_q=0, rdata_vec=0, vec_wr_q=0, op_q=0. While in IDLE all outputs are 0.
- Accept: only in IDLE with op_valid=1 and mem_op in {01,10}. On the accepting edge:
  - latch base_addr into addr_q, stride, wdata_vec, vec_wr_in, mem_op; idx=0.
  - go to LOAD (01) or STORE (10).
- stall is combinational:
  - 1 in IDLE while the accept condition holds.
  - 1 in LOAD, LOAD_WAIT, STORE.
  - 0 in DONE and otherwise, so the instruction advances out of the stage on the edge ending DONE.
- LOAD: mem_re=1, mem_addr=addr_q.
  - Each edge: addr_q += stride (mod 2^AW); idx++.
  - Lane idx-1 captures mem_rdata from the previous cycle's read.
  - The edge issuing idx=LANES-1 moves to LOAD_WAIT.
- LOAD_WAIT: mem_re=0; captures the last lane on its edge; goes to DONE.
- STORE: mem_we=1, mem_addr=addr_q, mem_wdata = latched lane idx.
  - Each edge: addr_q += stride; idx++.
  - After lane LANES-1 goes to DONE.
- DONE: done=1 for exactly one cycle; rdata_vec is valid.
  - vec_wr_out = latched vec_wr for loads, 00 for stores; otherwise vec_wr_out=0.
  - Next state IDLE unconditionally. No instruction is accepted in DONE.
- Timing, accept cycle = 0:
  - load: reads at cycles 1..LANES, done at cycle LANES+2.
  - store: writes at cycles 1..LANES, done at cycle LANES+1.
- rdata_vec updates lane-wise during LOAD/LOAD_WAIT and holds until the next load. Stores never modify it.
- mem_re and mem_we are never both 1. Both are 0 in IDLE, LOAD_WAIT and DONE.
- stride=0: all lanes use base_addr. Address overflow wraps silently.
- op_valid with mem_op 00/11: ignored, stall=0, no memory strobes.
- Changes on any input (including op_valid) during busy states are ignored; only latched values are used.
- Reset mid-operation: the next edge forces IDLE; strobes, done and stall drop at that edge. A partial rdata_vec is cleared to 0.

Test Plan:
1. Reset then idle: op_valid=0 for 5 cycles -> stall, done, mem_re, mem_we all 0; rdata_vec=0.
2. Load, LANES=4, base=0x0100, stride=2, memory holds 0x1111,0x2222,0x3333,0x4444, vec_wr_in=01:
   - mem_addr 0x0100,0x0102,0x0104,0x0106 on cycles 1-4.
   - done at cycle 6 with rdata_vec=0x4444_3333_2222_1111, vec_wr_out=01.
   - stall high cycles 0-5.
3. Store, base=0xFFFE, stride=1, wdata_vec=0xDDDD_CCCC_BBBB_AAAA:
   - writes AAAA@FFFE, BBBB@FFFF, CCCC@0000, DDDD@0001 (wrap).
   - done at cycle 5, vec_wr_out=00.
4. Back-to-back: load then store presented on consecutive instructions -> store accepted in the cycle after DONE; no overlap of strobes; each produces exactly one done pulse.
5. mem_op=11 and 00 with op_valid=1 -> no strobes, stall=0, done never asserts.
6. Reset asserted at load cycle 2 -> next cycle IDLE, mem_re=0, stall=0, rdata_vec=0; a fresh load then completes normally.

Source files
------------

// File: rtl/vec_mem_seq.sv
// vec_mem_seq: memory-stage sequencer that splits one vector load or store
// into LANES single-element accesses with a programmable stride. Upstream is
// held off with stall while busy. A completed load presents its vector and
// write-back control for one cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a live load/store control word
// LOAD      | issuing element reads; capturing the previous read's data
// LOAD_WAIT | no strobe; capturing the final lane's read data
// STORE     | issuing element writes from the latched store vector
// DONE      | one-cycle completion; upstream released on this edge
//
// All state updates on the falling edge of clk.
module vec_mem_seq #(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int AW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [1:0]          mem_op,
    input  logic [1:0]          vec_wr_in,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW-1:0]       stride,
    input  logic [LANES*DW-1:0] wdata_vec,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic [LANES*DW-1:0] rdata_vec,
    output logic [1:0]          vec_wr_out,
    output logic                done,
    output logic                stall
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_LOAD_WAIT = 3'd2;
    localparam logic [2:0] S_STORE     = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    logic [2:0]          state;
    logic [IW-1:0]       idx;
    logic [AW-1:0]       addr_q;
    logic [AW-1:0]       stride_q;
    logic [LANES*DW-1:0] wdata_q;
    logic [1:0]          vec_wr_q;
    logic [1:0]          op_q;

    logic accept;
    logic last_lane;

    assign accept    = (state == S_IDLE) && op_valid &&
                       ((mem_op == OP_LOAD) || (mem_op == OP_STORE));
    assign last_lane = (idx == IW'(LANES - 1));

    // Sequencer state, latched instruction fields and lane-wise load capture.
    always_ff @(negedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            addr_q    <= '0;
            stride_q  <= '0;
            wdata_q   <= '0;
            vec_wr_q  <= '0;
            op_q      <= '0;
            rdata_vec <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q   <= base_addr;
                        stride_q <= stride;
                        wdata_q  <= wdata_vec;
                        vec_wr_q <= vec_wr_in;
                        op_q     <= mem_op;
                        idx      <= '0;
                        state    <= (mem_op == OP_LOAD) ? S_LOAD : S_STORE;
                    end
                end
                S_LOAD: begin
                    addr_q <= addr_q + stride_q;
                    // read data lags the address by one cycle, so this edge
                    // completes the lane issued on the previous cycle
                    for (int i = 0; i < LANES - 1; i++) begin
                        if ((idx != '0) && (int'(idx) - 1 == i))
                            rdata_vec[i*DW +: DW] <= mem_rdata;
                    end
                    if (last_lane) begin
                        state <= S_LOAD_WAIT;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_LOAD_WAIT: begin
                    rdata_vec[(LANES-1)*DW +: DW] <= mem_rdata;
                    state <= S_DONE;
                end
                S_STORE: begin
                    addr_q <= addr_q + stride_q;
                    if (last_lane) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory strobes, completion outputs and upstream stall decoded from state.
    always_comb begin
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        vec_wr_out = 2'b00;
        done       = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                stall = accept;
            end
            S_LOAD: begin
                mem_re   = 1'b1;
                mem_addr = addr_q;
                stall    = 1'b1;
            end
            S_LOAD_WAIT: begin
                stall = 1'b1;
            end
            S_STORE: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                stall    = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    if (int'(idx) == i)
                        mem_wdata = wdata_q[i*DW +: DW];
                end
            end
            S_DONE: begin
                done       = 1'b1;
                vec_wr_out = (op_q == OP_LOAD) ? vec_wr_q : 2'b00;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_mem_seq.sv
// tb_vec_mem_seq: drives an instruction stream the way the execute/memory
// pipeline register would (advancing only on edges where stall is low),
// models a one-cycle-latency memory, and scores every strobe and completion
// against expectations queued when each instruction is presented.
module tb_vec_mem_seq;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int VW    = LANES * DW;

    logic          clk;
    logic          reset;
    logic          op_valid;
    logic [1:0]    mem_op;
    logic [1:0]    vec_wr_in;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic [VW-1:0] wdata_vec;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [VW-1:0] rdata_vec;
    logic [1:0]    vec_wr_out;
    logic          done;
    logic          stall;

    vec_mem_seq #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .mem_op     (mem_op),
        .vec_wr_in  (vec_wr_in),
        .base_addr  (base_addr),
        .stride     (stride),
        .wdata_vec  (wdata_vec),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rdata_vec  (rdata_vec),
        .vec_wr_out (vec_wr_out),
        .done       (done),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        int            cyc;
        logic [VW-1:0] rd;
        logic [1:0]    vwr;
    } done_t;

    acc_t  acc_q[$];
    done_t done_q[$];
    acc_t  ma;
    done_t md;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int st_a  = 0;
    int st_b  = 0;
    logic          mon_en = 1'b0;
    logic [VW-1:0] last_load = '0;

    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        case (a)
            16'h0100: return 16'h1111;
            16'h0102: return 16'h2222;
            16'h0104: return 16'h3333;
            16'h0106: return 16'h4444;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    // cycle number: cycle N ends at the falling edge that makes cyc N+1
    always @(negedge clk) cyc <= cyc + 1;

    // memory: writes land at the edge, read data appears one cycle later
    always @(negedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= mem_read(mem_addr);
    end

    // mid-cycle scoreboard on the rising edge
    always @(posedge clk) begin
        if (mon_en) begin
            chk("stall", {63'd0, stall}, {63'd0, (cyc >= st_a) && (cyc < st_b)});
            chk("re_we_excl", {63'd0, mem_re & mem_we}, 64'd0);
            while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
                chk("acc_missed_cyc", cyc, acc_q[0].cyc);
                void'(acc_q.pop_front());
            end
            if (mem_re || mem_we) begin
                if (acc_q.size() == 0) begin
                    chk("unexp_strobe", {62'd0, mem_re, mem_we}, 64'd0);
                end else begin
                    ma = acc_q.pop_front();
                    chk("acc_cyc", cyc, ma.cyc);
                    chk("acc_we", {63'd0, mem_we}, {63'd0, ma.we});
                    chk("acc_re", {63'd0, mem_re}, {63'd0, !ma.we});
                    chk("acc_addr", mem_addr, ma.addr);
                    if (ma.we) chk("acc_wdata", mem_wdata, ma.data);
                end
            end
            while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
                chk("done_missed_cyc", cyc, done_q[0].cyc);
                void'(done_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexp_done", {63'd0, done}, 64'd0);
                end else begin
                    md = done_q.pop_front();
                    chk("done_cyc", cyc, md.cyc);
                    chk("done_rdata", rdata_vec, md.rd);
                    chk("done_vwr", vec_wr_out, md.vwr);
                end
            end else begin
                chk("vwr_idle", vec_wr_out, 64'd0);
            end
        end
    end

    task automatic push_expect(input logic [1:0] op, input logic [AW-1:0] base,
                               input logic [AW-1:0] st, input logic [VW-1:0] wd,
                               input logic [1:0] vwr, input int n, output int dcyc);
        acc_t          a;
        done_t         d;
        logic [AW-1:0] ad;
        logic [VW-1:0] rv;
        ad = base;
        rv = '0;
        for (int i = 0; i < LANES; i++) begin
            a.cyc  = n + 1 + i;
            a.we   = (op == 2'b10);
            a.addr = ad;
            a.data = wd[i*DW +: DW];
            acc_q.push_back(a);
            if (op == 2'b01) rv[i*DW +: DW] = mem_read(ad);
            ad = ad + st;
        end
        if (op == 2'b01) begin
            dcyc      = n + LANES + 2;
            d.rd      = rv;
            d.vwr     = vwr;
            last_load = rv;
        end else begin
            dcyc  = n + LANES + 1;
            d.rd  = last_load;
            d.vwr = 2'b00;
        end
        d.cyc = dcyc;
        done_q.push_back(d);
    endtask

    // present one instruction and hold it until an edge with stall low
    task automatic run_instr(input logic valid, input logic [1:0] op,
                             input logic [AW-1:0] base, input logic [AW-1:0] st,
                             input logic [VW-1:0] wd, input logic [1:0] vwr);
        int   n_edges;
        int   dcyc;
        int   explen;
        logic s;
        logic fin;
        op_valid  = valid;
        mem_op    = op;
        base_addr = base;
        stride    = st;
        wdata_vec = wd;
        vec_wr_in = vwr;
        if (valid && (op == 2'b01 || op == 2'b10)) begin
            push_expect(op, base, st, wd, vwr, cyc, dcyc);
            st_a   = cyc;
            st_b   = dcyc;
            explen = dcyc - cyc + 1;
        end else begin
            st_a   = 0;
            st_b   = 0;
            explen = 1;
        end
        n_edges = 0;
        fin     = 1'b0;
        while (!fin) begin
            @(negedge clk);
            s = stall;
            n_edges++;
            if (!s) begin
                fin = 1'b1;
            end else if (n_edges >= 50) begin
                chk("busy_timeout", n_edges, explen);
                fin = 1'b1;
            end else begin
                #1;
                // busy: the sequencer must ignore whatever sits on its inputs
                base_addr = AW'($urandom);
                stride    = AW'($urandom);
                wdata_vec = {$urandom, $urandom};
                vec_wr_in = 2'($urandom);
                mem_op    = 2'($urandom_range(1, 2));
                op_valid  = 1'b1;
            end
        end
        #1;
        chk("busy_len", n_edges, explen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int a0;
        int dcyc;
        reset     = 1'b1;
        op_valid  = 1'b0;
        mem_op    = 2'b00;
        vec_wr_in = 2'b00;
        base_addr = '0;
        stride    = '0;
        wdata_vec = '0;
        repeat (3) @(negedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // idle after reset
        for (int i = 0; i < 5; i++) run_instr(1'b0, 2'b00, '0, '0, '0, 2'b00);
        chk("idle_rdata", rdata_vec, 64'd0);
        chk("idle_done", {63'd0, done}, 64'd0);
        chk("idle_re", {63'd0, mem_re}, 64'd0);

        // basic load
        run_instr(1'b1, 2'b01, 16'h0100, 16'd2, '0, 2'b01);
        chk("load_vec", rdata_vec, 64'h4444_3333_2222_1111);

        // store across the address wrap, vec_wr_in must not reach the output
        run_instr(1'b1, 2'b10, 16'hFFFE, 16'd1, 64'hDDDD_CCCC_BBBB_AAAA, 2'b10);
        chk("st_mem_fffe", mem_read(16'hFFFE), 64'hAAAA);
        chk("st_mem_ffff", mem_read(16'hFFFF), 64'hBBBB);
        chk("st_mem_0000", mem_read(16'h0000), 64'hCCCC);
        chk("st_mem_0001", mem_read(16'h0001), 64'hDDDD);
        chk("st_keeps_vec", rdata_vec, 64'h4444_3333_2222_1111);

        // back-to-back load then store
        run_instr(1'b1, 2'b01, 16'h0000, 16'd1, '0, 2'b11);
        run_instr(1'b1, 2'b10, 16'h0800, 16'h0010, 64'h0123_4567_89AB_CDEF, 2'b01);

        // non-memory ops with op_valid high, and a load without op_valid
        run_instr(1'b1, 2'b11, 16'h0100, 16'd2, '0, 2'b01);
        run_instr(1'b1, 2'b00, 16'h0100, 16'd2, '0, 2'b01);
        run_instr(1'b0, 2'b01, 16'h0100, 16'd2, '0, 2'b01);

        // reset during the second read of a load
        op_valid  = 1'b1;
        mem_op    = 2'b01;
        base_addr = 16'h0200;
        stride    = 16'd3;
        wdata_vec = '0;
        vec_wr_in = 2'b10;
        a0 = cyc;
        push_expect(2'b01, 16'h0200, 16'd3, '0, 2'b10, a0, dcyc);
        st_a = a0;
        st_b = dcyc;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        reset    = 1'b1;
        op_valid = 1'b0;
        st_b     = a0 + 3;
        @(negedge clk);
        #1;
        reset = 1'b0;
        acc_q.delete();
        done_q.delete();
        last_load = '0;
        @(posedge clk);
        chk("rst_re", {63'd0, mem_re}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_rdata", rdata_vec, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        #1;
        run_instr(1'b1, 2'b01, 16'h0100, 16'd2, '0, 2'b10);
        chk("post_rst_vec", rdata_vec, 64'h4444_3333_2222_1111);

        // zero stride: every lane hits the base address
        run_instr(1'b1, 2'b10, 16'h3000, 16'd0, 64'h9999_8888_7777_6666, 2'b00);
        chk("st0_mem", mem_read(16'h3000), 64'h9999);
        run_instr(1'b1, 2'b01, 16'h3000, 16'd0, '0, 2'b01);

        // random mix
        for (int i = 0; i < 8; i++) begin
            run_instr(1'b1, 2'($urandom_range(1, 2)), AW'($urandom), AW'($urandom_range(0, 40)),
                      {$urandom, $urandom}, 2'($urandom));
        end

        op_valid = 1'b0;
        mem_op   = 2'b00;
        st_a     = 0;
        st_b     = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("acc_q_left", acc_q.size(), 64'd0);
        chk("done_q_left", done_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
